// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame decoder.
package spi_frame_pkg;

   typedef enum logic [1:0] {
      CMD,
      WR_DATA,
      RD_DATA,
      DRAIN
   } state_t;

   localparam int unsigned CMD_WRITE_BIT = 7;
   localparam logic [7:0]  TX_FILL       = 8'hFF;
   localparam int unsigned ADDR_BITS     = 7;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      for (r = 0; (64'd1 << r) < 64'(value); r++) begin
      end
      return r;
   endfunction

endpackage

// File: rtl/spi_frame_decoder.sv
// Decodes command|address|data SPI frames into single-cycle register bus
// writes and reads, and returns status / read data to the SPI secondary.
module spi_frame_decoder
   import spi_frame_pkg::*;
#(
   parameter int unsigned DATA_BYTES = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      frame_active,
   input  logic                      byte_valid,
   input  logic [7:0]                rx_byte,
   output logic [7:0]                tx_byte,
   input  logic [7:0]                status_in,
   output logic                      reg_wr_en,
   output logic                      reg_rd_en,
   output logic [ADDR_BITS-1:0]      reg_addr,
   output logic [8*DATA_BYTES-1:0]   reg_wdata,
   input  logic [8*DATA_BYTES-1:0]   reg_rdata,
   output logic                      frame_err
);

   localparam int unsigned W     = 8 * DATA_BYTES;
   localparam int unsigned CNT_W = clog2(DATA_BYTES) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BYTES - 1);

   state_t           state, state_post, next_state;
   logic [CNT_W-1:0] byte_cnt;
   logic [W-1:0]     tx_shift;
   logic             frame_active_q;
   logic             started;
   logic             rd_load;
   logic             accept;
   logic             wr_done, rd_start, wr_shift, rd_shift, err_now;

   // A byte arriving on the cycle chip-select drops is still processed.
   assign accept = byte_valid && (frame_active || frame_active_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= CMD;
      else     state <= next_state;
   end

   always_comb begin
      state_post = state;
      wr_done    = 1'b0;
      rd_start   = 1'b0;
      wr_shift   = 1'b0;
      rd_shift   = 1'b0;
      if (accept) begin
         case (state)
            CMD: begin
               state_post = rx_byte[CMD_WRITE_BIT] ? WR_DATA : RD_DATA;
               rd_start   = !rx_byte[CMD_WRITE_BIT];
            end
            WR_DATA: begin
               wr_shift = 1'b1;
               if (byte_cnt == LAST_CNT) begin
                  wr_done    = 1'b1;
                  state_post = DRAIN;
               end
            end
            RD_DATA: begin
               rd_shift = 1'b1;
               if (byte_cnt == LAST_CNT) state_post = DRAIN;
            end
            DRAIN: state_post = DRAIN;
         endcase
      end
      next_state = frame_active ? state_post : CMD;
      err_now    = !frame_active && (state == WR_DATA || state == RD_DATA)
                   && (state_post != DRAIN);
   end

   always_comb begin
      tx_byte = TX_FILL;
      case (state)
         CMD:     if (started) tx_byte = status_in;
         RD_DATA: tx_byte = tx_shift[W-1 -: 8];
         default: tx_byte = TX_FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt       <= '0;
         tx_shift       <= '0;
         frame_active_q <= 1'b0;
         started        <= 1'b0;
         rd_load        <= 1'b0;
         reg_wr_en      <= 1'b0;
         reg_rd_en      <= 1'b0;
         frame_err      <= 1'b0;
         reg_addr       <= '0;
         reg_wdata      <= '0;
      end else begin
         frame_active_q <= frame_active;
         started        <= 1'b1;
         reg_wr_en      <= wr_done;
         reg_rd_en      <= rd_start;
         rd_load        <= reg_rd_en;
         frame_err      <= err_now;
         if (accept && state == CMD) begin
            reg_addr <= rx_byte[ADDR_BITS-1:0];
            byte_cnt <= '0;
         end
         if (rd_load && state == RD_DATA) tx_shift <= reg_rdata;
         if (wr_shift) begin
            reg_wdata <= W'({reg_wdata, rx_byte});
            byte_cnt  <= byte_cnt + CNT_W'(1);
         end
         if (rd_shift) begin
            tx_shift <= tx_shift << 8;
            byte_cnt <= byte_cnt + CNT_W'(1);
         end
         if (!frame_active) begin
            byte_cnt <= '0;
            tx_shift <= '0;
         end
      end
   end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Randomised scoreboard bench for spi_frame_decoder with a register-slave model.
module tb_spi_frame_decoder;

   localparam int DB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          frame_active;
   logic          byte_valid;
   logic [7:0]    rx_byte;
   logic [7:0]    tx_byte;
   logic [7:0]    status_in;
   logic          reg_wr_en;
   logic          reg_rd_en;
   logic [6:0]    reg_addr;
   logic [31:0]   reg_wdata;
   logic [31:0]   reg_rdata;
   logic          frame_err;

   int errors = 0;
   int checks = 0;

   logic [6:0]  wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [6:0]  rd_addr_q[$];
   int          err_q[$];

   logic [31:0] model_mem [0:127];
   logic [31:0] bus_mem   [0:127];

   always #5 clk = ~clk;

   spi_frame_decoder #(.DATA_BYTES(DB)) dut (
      .clk(clk), .rst(rst), .frame_active(frame_active), .byte_valid(byte_valid),
      .rx_byte(rx_byte), .tx_byte(tx_byte), .status_in(status_in),
      .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .frame_err(frame_err)
   );

   function automatic logic [31:0] init_val(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, b, b, b} ^ 32'hA5C3_0F69;
   endfunction

   // Register slave: stores writes, returns read data exactly one cycle after reg_rd_en.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 128; i++) bus_mem[i] <= init_val(i);
         reg_rdata <= '0;
      end else begin
         if (reg_wr_en) bus_mem[reg_addr] <= reg_wdata;
         reg_rdata <= reg_rd_en ? bus_mem[reg_addr] : $urandom;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reg_wr_en) begin
         if (wr_addr_q.size() == 0) chk("unexpected_wr_en", 32'd1, 32'd0);
         else begin
            chk("wr_addr", 32'(reg_addr), 32'(wr_addr_q.pop_front()));
            chk("wr_data", reg_wdata, wr_data_q.pop_front());
         end
      end
      if (reg_rd_en) begin
         if (rd_addr_q.size() == 0) chk("unexpected_rd_en", 32'd1, 32'd0);
         else chk("rd_addr", 32'(reg_addr), 32'(rd_addr_q.pop_front()));
      end
      if (frame_err) begin
         if (err_q.size() == 0) chk("unexpected_frame_err", 32'd1, 32'd0);
         else void'(err_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gap();
      repeat (4) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit drop, output logic [7:0] seen);
      seen       = tx_byte;
      rx_byte    = b;
      byte_valid = 1'b1;
      if (drop) frame_active = 1'b0;
      tick();
      byte_valid = 1'b0;
      rx_byte    = 8'($urandom);
   endtask

   task automatic frame_begin(input logic [7:0] st);
      status_in    = st;
      frame_active = 1'b1;
      tick();
      tick();
      chk("tx_status_cmd", 32'(tx_byte), 32'(st));
   endtask

   task automatic frame_end();
      frame_active = 1'b0;
      repeat (4) tick();
      chk("tx_status_idle", 32'(tx_byte), 32'(status_in));
   endtask

   // nbytes < DB aborts mid-write; drop_last drops chip-select with the final byte.
   task automatic do_write(input logic [7:0] st, input logic [6:0] addr, input logic [31:0] data,
                           input int nbytes, input bit drop_last, input int extra);
      logic [7:0] seen;
      logic [7:0] b;
      if (nbytes == DB) begin
         wr_addr_q.push_back(addr);
         wr_data_q.push_back(data);
         model_mem[addr] = data;
      end else begin
         err_q.push_back(1);
      end
      frame_begin(st);
      send_byte({1'b1, addr}, 1'b0, seen);
      chk("wr_cmd_tx", 32'(seen), 32'(st));
      gap();
      for (int i = 0; i < nbytes; i++) begin
         b = data[31 - 8*i -: 8];
         send_byte(b, drop_last && (i == DB - 1), seen);
         chk("wr_data_tx", 32'(seen), 32'hFF);
         if (i == DB - 1) chk("wr_latency", 32'(reg_wr_en), 32'd1);
         gap();
      end
      if (nbytes == DB && !drop_last) begin
         chk("drain_tx", 32'(tx_byte), 32'hFF);
         for (int i = 0; i < extra; i++) begin
            send_byte(8'($urandom), 1'b0, seen);
            chk("drain_extra_tx", 32'(seen), 32'hFF);
            gap();
         end
      end
      if (drop_last) chk("tx_after_drop", 32'(tx_byte), 32'(status_in));
      else frame_end();
   endtask

   task automatic do_read(input logic [7:0] st, input logic [6:0] addr, input int nbytes);
      logic [7:0]  seen;
      logic [31:0] exp;
      exp = model_mem[addr];
      rd_addr_q.push_back(addr);
      if (nbytes < DB) err_q.push_back(1);
      frame_begin(st);
      send_byte({1'b0, addr}, 1'b0, seen);
      chk("rd_cmd_tx", 32'(seen), 32'(st));
      chk("rd_latency", 32'(reg_rd_en), 32'd1);
      gap();
      for (int i = 0; i < nbytes; i++) begin
         send_byte(8'($urandom), 1'b0, seen);
         chk("rd_data_tx", 32'(seen), 32'(exp[31 - 8*i -: 8]));
         gap();
      end
      if (nbytes == DB) chk("rd_drain_tx", 32'(tx_byte), 32'hFF);
      frame_end();
   endtask

   initial begin
      logic [7:0] seen;
      int kind;
      for (int i = 0; i < 128; i++) model_mem[i] = init_val(i);
      rst          = 1'b1;
      frame_active = 1'b0;
      byte_valid   = 1'b0;
      rx_byte      = 8'h00;
      status_in    = 8'h3C;
      repeat (3) tick();
      chk("rst_tx", 32'(tx_byte), 32'hFF);
      chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
      chk("rst_rd_en", 32'(reg_rd_en), 32'd0);
      chk("rst_err", 32'(frame_err), 32'd0);
      chk("rst_addr", 32'(reg_addr), 32'd0);
      chk("rst_wdata", reg_wdata, 32'd0);
      rst = 1'b0;
      chk("tx_before_first_edge", 32'(tx_byte), 32'hFF);
      tick();
      chk("tx_after_first_edge", 32'(tx_byte), 32'h3C);

      do_write(8'hA5, 7'h05, 32'h1234_5678, DB, 1'b0, 0);
      do_write(8'h11, 7'h05, 32'hDEAD_BEEF, DB, 1'b0, 0);
      do_read (8'hA5, 7'h05, DB);
      do_write(8'h22, 7'h03, 32'hCAFE_F00D, 2, 1'b0, 0);
      do_read (8'h33, 7'h03, DB);
      do_write(8'h44, 7'h0A, 32'h0BAD_C0DE, DB, 1'b1, 0);
      do_read (8'h55, 7'h0A, DB);
      do_write(8'h66, 7'h0B, 32'h8765_4321, DB, 1'b0, 6);
      do_read (8'h77, 7'h0B, 2);

      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 4)
            do_write(8'($urandom), 7'($urandom_range(0, 7)), $urandom, DB, 1'b0,
                     int'($urandom_range(0, 2)));
         else if (kind < 7)
            do_read(8'($urandom), 7'($urandom_range(0, 7)), DB);
         else if (kind == 7)
            do_write(8'($urandom), 7'($urandom_range(0, 7)), $urandom,
                     int'($urandom_range(0, DB - 1)), 1'b0, 0);
         else if (kind == 8)
            do_read(8'($urandom), 7'($urandom_range(0, 7)), int'($urandom_range(0, DB - 1)));
         else
            do_write(8'($urandom), 7'($urandom_range(0, 7)), $urandom, DB, 1'b1, 0);
      end

      // Reset in the middle of a read: one read strobe already issued, nothing after.
      rd_addr_q.push_back(7'h05);
      frame_begin(8'h5A);
      send_byte(8'h05, 1'b0, seen);
      gap();
      send_byte(8'h00, 1'b0, seen);
      chk("pre_rst_rd_tx", 32'(seen), 32'(model_mem[5][31:24]));
      tick();
      rst          = 1'b1;
      frame_active = 1'b0;
      tick();
      chk("midrst_tx", 32'(tx_byte), 32'hFF);
      chk("midrst_wr_en", 32'(reg_wr_en), 32'd0);
      chk("midrst_rd_en", 32'(reg_rd_en), 32'd0);
      chk("midrst_err", 32'(frame_err), 32'd0);
      chk("midrst_addr", 32'(reg_addr), 32'd0);
      chk("midrst_wdata", reg_wdata, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_tx", 32'(tx_byte), 32'h5A);
      repeat (4) tick();

      chk("pending_wr", 32'(wr_addr_q.size()), 32'd0);
      chk("pending_rd", 32'(rd_addr_q.size()), 32'd0);
      chk("pending_err", 32'(err_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_frame_decoder.md
# spi_frame_decoder

Byte-level transaction decoder sitting directly downstream of the SPI secondary shift register. Consumes each received byte, parses `command | address | data` frames, and drives a single-master register bus (write or read). Returns the status byte and read data to the host by presenting the next byte to transmit back to the SPI secondary. All logic is in the `clk` domain; `byte_valid` and `frame_active` arrive already synchronous to `clk`.

## Interface
- `DATA_BYTES`, default 4: payload bytes per transaction; register width is `8*DATA_BYTES`.
- `ADDR_BITS`, fixed 7: taken from the command byte.
- Clock and reset: clock `clk`; reset `rst`, asynchronous, active-high.
- `clk` input, 1: system clock.
- `rst` input, 1: asynchronous active-high reset.
- `frame_active` input, 1: chip-select asserted (inverted `~enable`, synchronised).
- `byte_valid` input, 1: one-cycle pulse, a received byte is on `rx_byte`.
- `rx_byte` input, 8: received byte.
- `tx_byte` output, 8: byte the SPI secondary shifts out in the next word.
- `status_in` input, 8: status byte returned during the command byte.
- `reg_wr_en` output, 1: one-cycle write strobe.
- `reg_rd_en` output, 1: one-cycle read strobe.
- `reg_addr` output, 7: register address.
- `reg_wdata` output, `8*DATA_BYTES`: write data.
- `reg_rdata` input, `8*DATA_BYTES`: read data, valid exactly 1 cycle after `reg_rd_en`.
- `frame_err` output, 1: one-cycle pulse when a frame ends mid-transaction.

## Operation
- **Command byte:** first byte of a frame. Bit 7 set means write, clear means read. Bits 6:0 are the address.
- **States:**
  - CMD: waiting for the command byte.
  - WR_DATA: collecting payload bytes.
  - RD_DATA: sending payload bytes.
  - DRAIN: transaction complete; further bytes are ignored.
- **CMD + `byte_valid`:**
  - Latch `reg_addr` and clear `byte_cnt`.
  - Write command: go to WR_DATA.
  - Read command: go to RD_DATA and pulse `reg_rd_en` on the next cycle.
- **WR_DATA:** each byte shifts into `reg_wdata`, MSB first.
  - On byte number `DATA_BYTES`, pulse `reg_wr_en` on the next cycle with the complete `reg_wdata`, then go to DRAIN.
- **RD_DATA:**
  - `reg_rdata` is loaded into the tx shift register on the cycle after `reg_rd_en`.
  - `tx_byte` shows the MSB byte.
  - Each `byte_valid` (host dummy byte) shifts the next byte into `tx_byte`.
  - After `DATA_BYTES` bytes, go to DRAIN.
- **`tx_byte` source:** `status_in` in CMD, sampled live; read-data byte in RD_DATA; 0xFF in WR_DATA and DRAIN.
- **`byte_cnt`:** width `clog2(DATA_BYTES)+1`. It never wraps within a transaction, and DRAIN holds it.
- **Frame end** (`frame_active` low), from any state:
  - Next state is CMD, and `byte_cnt` and the tx shift register are cleared.
  - A partial write is discarded; no `reg_wr_en`.
  - `frame_err` pulses if the state was WR_DATA or RD_DATA.
- **`byte_valid` while `frame_active` low:** ignored.
- **`byte_valid` and `frame_active` falling in the same cycle:** the byte is processed first, then the return to CMD.
  - If that byte completes a write, the write commits and there is no `frame_err`.
- **Reset mid-transaction:** returns to CMD immediately; no strobes are issued.

## Timing
- Reset values:
  - state CMD
  - `reg_wr_en`, `reg_rd_en`, `frame_err` = 0
  - `reg_addr` = 0, `reg_wdata` = 0
  - `tx_byte` = 0xFF until the first clock edge after reset, then `status_in`
- Write latency: `reg_wr_en` is high in cycle N+1 when the last data byte has `byte_valid` in cycle N.
- Read latency:
  - Command `byte_valid` in cycle N, `reg_rd_en` in N+1, `reg_rdata` sampled in N+2.
  - `tx_byte` holds the first data byte from N+3.
  - Upstream guarantees at least 8 `sck` periods between bytes, which is at least 4 `clk` cycles.
- `tx_byte` changes only on the cycle after `byte_valid`, a state change, or a frame end. It is registered with no combinational path from `rx_byte`.
- Strobes are exactly one cycle; at most one strobe per frame.

## Structure
- Package `spi_frame_pkg` holds:
  - the state enum (CMD, WR_DATA, RD_DATA, DRAIN)
  - `CMD_WRITE_BIT` = 7
  - `TX_FILL` = 8'hFF
  - `ADDR_BITS` = 7
  - the `clog2` function
- No sub-module. The tx/rx shift registers and the FSM live in one module.

## Test plan
- Write 0x85 + bytes 12 34 56 78 → one `reg_wr_en`, `reg_addr`=0x05, `reg_wdata`=0x12345678, no `frame_err`.
- Read 0x05 with `reg_rdata`=0xDEADBEEF → `reg_rd_en` 1 cycle after the command byte; `tx_byte` sequence DE, AD, BE, EF; then FF.
- `status_in`=0xA5 at frame start → `tx_byte`=0xA5 while in CMD.
- Write 0x83 + 2 bytes, then `frame_active` low → no `reg_wr_en`, `frame_err` pulses once, next frame decodes normally.
- Last write byte `byte_valid` in the same cycle as `frame_active` falling → `reg_wr_en` fires and there is no `frame_err`; 6 extra bytes after a complete write → ignored in DRAIN, `tx_byte`=0xFF.
- `rst` asserted during RD_DATA → all outputs at reset values next cycle; no strobes.
